// File: rtl/end_screen_fx.sv
`default_nettype none
// ============================================================================
//  Module      : end_screen_fx
//  Description : Animation and compositing engine for the 96x64 OLED
//                end-of-game screen. Combines a blinking glyph layer, a
//                static glyph layer and an LFSR-generated field of 2x2 stars
//                into one registered RGB565 pixel. The tick rate, blink
//                period, star refresh period, star count and LFSR seed are
//                all parameters.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock         in   1   system clock
//    reset_n       in   1   asynchronous active-low reset
//    restart       in   1   synchronous pulse, restarts the animation
//    pix_index     in  13   pixel index from the OLED driver
//    blink_mask    in   1   blinking-layer glyph hit for pix_index
//    static_mask   in   1   static-layer glyph hit for pix_index
//    blink_colour  in  16   RGB565 colour of the blinking layer
//    static_colour in  16   RGB565 colour of the static layer
//    oled_data     out 16   composed pixel, one cycle after pix_index
//    visible       out  1   blinking layer currently shown
//    regen_busy    out  1   star regeneration in progress
//    tick          out  1   one-cycle pulse per animation tick
// ============================================================================
module end_screen_fx #(
    parameter int          WIDTH       = 96,
    parameter int          HEIGHT      = 64,
    parameter int          TICK_CYCLES = 25000,
    parameter int          BLINK_TICKS = 240,
    parameter int          STAR_TICKS  = 1,
    parameter int          NUM_STARS   = 12,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter logic [15:0] STAR_COL_A  = 16'h07BF,
    parameter logic [15:0] STAR_COL_B  = 16'h97E0,
    parameter logic [15:0] BG_COL      = 16'h0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        restart,
    input  logic [12:0] pix_index,
    input  logic        blink_mask,
    input  logic        static_mask,
    input  logic [15:0] blink_colour,
    input  logic [15:0] static_colour,
    output logic [15:0] oled_data,
    output logic        visible,
    output logic        regen_busy,
    output logic        tick
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int TICK_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int STAR_W  = (STAR_TICKS  > 1) ? $clog2(STAR_TICKS)  : 1;
    localparam int IDX_W   = (NUM_STARS   > 1) ? $clog2(NUM_STARS)   : 1;

    localparam logic [TICK_W-1:0]  C_TICK_LAST  = TICK_W'(TICK_CYCLES - 1);
    localparam logic [BLINK_W-1:0] C_BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);
    localparam logic [STAR_W-1:0]  C_STAR_LAST  = STAR_W'(STAR_TICKS - 1);
    localparam logic [IDX_W-1:0]   C_IDX_LAST   = IDX_W'(NUM_STARS - 1);

    // A zero seed would lock the LFSR at zero forever.
    localparam logic [15:0] C_SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] C_LFSR_TAPS = 16'hB400;

    // Stars are 2x2, so the top-left corner must stay one pixel away from
    // the right and bottom edges.
    localparam logic [6:0]  C_X_LAST    = 7'(WIDTH - 1);
    localparam logic [5:0]  C_Y_LAST    = 6'(HEIGHT - 1);
    localparam logic [5:0]  C_Y_CLAMP   = 6'(HEIGHT - 2);

    localparam logic [12:0] C_WIDTH13   = 13'(WIDTH);
    localparam logic [13:0] C_NPIX      = 14'(WIDTH * HEIGHT);

    // ------------------------------------------------------------------
    // Tick generator
    // ------------------------------------------------------------------
    logic [TICK_W-1:0] r_tick_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= '0;
            tick       <= 1'b0;
        end else if (restart) begin
            r_tick_cnt <= '0;
            tick       <= 1'b0;
        end else if (r_tick_cnt == C_TICK_LAST) begin
            r_tick_cnt <= '0;
            tick       <= 1'b1;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            tick       <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Blink and star-refresh dividers, both advanced by the tick pulse
    // ------------------------------------------------------------------
    logic [BLINK_W-1:0] r_blink_cnt;
    logic [STAR_W-1:0]  r_star_cnt;
    logic               w_regen_req;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_cnt <= '0;
            r_star_cnt  <= '0;
            visible     <= 1'b0;
        end else if (restart) begin
            r_blink_cnt <= '0;
            r_star_cnt  <= '0;
            visible     <= 1'b1;
        end else if (tick) begin
            if (r_blink_cnt == C_BLINK_LAST) begin
                r_blink_cnt <= '0;
                visible     <= ~visible;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
            end

            if (r_star_cnt == C_STAR_LAST) begin
                r_star_cnt <= '0;
            end else begin
                r_star_cnt <= r_star_cnt + STAR_W'(1);
            end
        end
    end

    // Restart wins over a coincident tick, so the request is suppressed.
    assign w_regen_req = tick && !restart && (r_star_cnt == C_STAR_LAST);

    // ------------------------------------------------------------------
    // Regeneration FSM
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_REGEN = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_boot;       // forces one regeneration after reset
    logic [IDX_W-1:0] r_idx;
    logic             w_last;

    assign w_last = (r_idx == C_IDX_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                // Requests only land here; one arriving mid-regeneration
                // is simply lost.
                if (restart || w_regen_req || r_boot) begin
                    w_state_next = ST_REGEN;
                end
            end
            ST_REGEN: begin
                if (restart) begin
                    w_state_next = ST_REGEN;
                end else if (w_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign regen_busy = (r_state == ST_REGEN);

    // ------------------------------------------------------------------
    // LFSR and star table
    // ------------------------------------------------------------------
    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_next;
    logic [6:0]  w_new_x;
    logic [5:0]  w_new_y;
    logic        r_stars_valid;
    logic [6:0]  r_star_x [NUM_STARS];
    logic [5:0]  r_star_y [NUM_STARS];

    // Galois form, shifting right.
    assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ C_LFSR_TAPS) : (r_lfsr >> 1);

    // Fold raw LFSR bits into legal top-left star coordinates.
    assign w_new_x = (r_lfsr[6:0] >= C_X_LAST) ? (r_lfsr[6:0] - C_X_LAST) : r_lfsr[6:0];
    assign w_new_y = (r_lfsr[12:7] == C_Y_LAST) ? C_Y_CLAMP : r_lfsr[12:7];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_boot        <= 1'b1;
            r_idx         <= '0;
            r_lfsr        <= C_SEED_EFF;
            r_stars_valid <= 1'b0;
            for (int k = 0; k < NUM_STARS; k++) begin
                r_star_x[k] <= '0;
                r_star_y[k] <= '0;
            end
        end else begin
            r_boot <= 1'b0;
            if (restart) begin
                // Aborts any regeneration in flight and starts over from
                // the seed; no star is written in this cycle.
                r_idx         <= '0;
                r_lfsr        <= C_SEED_EFF;
                r_stars_valid <= 1'b0;
            end else if (r_state == ST_IDLE) begin
                if (w_regen_req || r_boot) begin
                    r_idx         <= '0;
                    r_stars_valid <= 1'b0;
                end
            end else begin
                // The LFSR keeps running across regenerations so each new
                // star field differs from the previous one.
                r_star_x[r_idx] <= w_new_x;
                r_star_y[r_idx] <= w_new_y;
                r_lfsr          <= w_lfsr_next;
                if (w_last) begin
                    r_stars_valid <= 1'b1;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Star hit test for the current pixel
    // ------------------------------------------------------------------
    logic [12:0]          w_px;
    logic [12:0]          w_py;
    logic [NUM_STARS-1:0] w_hit;
    logic                 w_star_hit;
    logic                 w_star_odd;

    assign w_px = pix_index % C_WIDTH13;
    assign w_py = pix_index / C_WIDTH13;

    generate
        for (genvar k = 0; k < NUM_STARS; k++) begin : g_star
            logic [12:0] w_sx;
            logic [12:0] w_sy;
            assign w_sx     = {6'd0, r_star_x[k]};
            assign w_sy     = {7'd0, r_star_y[k]};
            assign w_hit[k] = (w_px >= w_sx) && (w_px <= w_sx + 13'd1) &&
                              (w_py >= w_sy) && (w_py <= w_sy + 13'd1);
        end
    endgenerate

    // Scan from the top index down so the lowest hitting star decides
    // the colour.
    always_comb begin
        w_star_hit = 1'b0;
        w_star_odd = 1'b0;
        for (int k = NUM_STARS - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                w_star_hit = 1'b1;
                w_star_odd = ((k % 2) != 0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output compositing
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            oled_data <= BG_COL;
        end else if ({1'b0, pix_index} >= C_NPIX) begin
            oled_data <= BG_COL;
        end else if (visible && blink_mask) begin
            oled_data <= blink_colour;
        end else if (static_mask) begin
            oled_data <= static_colour;
        end else if (r_stars_valid && w_star_hit) begin
            oled_data <= w_star_odd ? STAR_COL_B : STAR_COL_A;
        end else begin
            oled_data <= BG_COL;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_end_screen_fx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_end_screen_fx
//  Description : Self-checking bench for end_screen_fx. Three instances:
//                u_main (default parameters) for star placement, restart
//                and compositing priority; u_blink (4-cycle tick, 3-tick
//                blink) for tick/visible timing; u_regen (4 stars,
//                regeneration every 2 ticks) for periodic star refresh.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_end_screen_fx;

    localparam logic [15:0] C_COL_A  = 16'h07BF;
    localparam logic [15:0] C_COL_B  = 16'h97E0;
    localparam logic [15:0] C_BG     = 16'h0000;
    localparam logic [15:0] C_BLINK  = 16'hF800;
    localparam logic [15:0] C_STATIC = 16'h001F;

    // Star pixels derived from the seed 0xACE1 and its successors.
    localparam logic [12:0] C_S0  = 13'(25 * 96 + 2);   // star0 (2,25)
    localparam logic [12:0] C_S0B = 13'(26 * 96 + 3);   // star0 lower-right
    localparam logic [12:0] C_S1  = 13'(4 * 96 + 17);   // star1 (17,4), L=E270
    localparam logic [12:0] C_S1B = 13'(5 * 96 + 18);
    localparam logic [12:0] C_R0  = 13'(56 * 96 + 78);  // 2nd regen star0, L=1C4E
    localparam logic [12:0] C_R1  = 13'(28 * 96 + 39);  // 2nd regen star1, L=0E27

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        restart_m = 1'b0;
    logic        restart_0 = 1'b0;
    logic [12:0] pix_m = '0;
    logic [12:0] pix_1 = '0;
    logic        bm_m = 1'b0;
    logic        sm_m = 1'b0;
    logic        zero_b = 1'b0;
    logic [15:0] blink_col = C_BLINK;
    logic [15:0] static_col = C_STATIC;

    logic [15:0] oled_m, oled_0, oled_1;
    logic        vis_m, vis_0, vis_1;
    logic        busy_m, busy_0, busy_1;
    logic        tick_m, tick_0, tick_1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    end_screen_fx u_main (
        .clock(clock), .reset_n(reset_n), .restart(restart_m),
        .pix_index(pix_m), .blink_mask(bm_m), .static_mask(sm_m),
        .blink_colour(blink_col), .static_colour(static_col),
        .oled_data(oled_m), .visible(vis_m), .regen_busy(busy_m), .tick(tick_m)
    );

    end_screen_fx #(.TICK_CYCLES(4), .BLINK_TICKS(3)) u_blink (
        .clock(clock), .reset_n(reset_n), .restart(restart_0),
        .pix_index(pix_1), .blink_mask(zero_b), .static_mask(zero_b),
        .blink_colour(blink_col), .static_colour(static_col),
        .oled_data(oled_0), .visible(vis_0), .regen_busy(busy_0), .tick(tick_0)
    );

    end_screen_fx #(.TICK_CYCLES(4), .STAR_TICKS(2), .NUM_STARS(4)) u_regen (
        .clock(clock), .reset_n(reset_n), .restart(restart_0),
        .pix_index(pix_1), .blink_mask(zero_b), .static_mask(zero_b),
        .blink_colour(blink_col), .static_colour(static_col),
        .oled_data(oled_1), .visible(vis_1), .regen_busy(busy_1), .tick(tick_1)
    );

    typedef struct {
        logic [12:0] pix;
        logic        bm;
        logic        sm;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_vec(input int i);
        pix_m = vecs[i].pix;
        bm_m  = vecs[i].bm;
        sm_m  = vecs[i].sm;
        step();
        check($sformatf("vec%0d", i), oled_m, vecs[i].exp);
    endtask

    // Counts consecutive sampled-high cycles of the main busy flag.
    task automatic count_busy(output int cnt);
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            if (!busy_m) break;
            cnt++;
            step();
        end
    endtask

    // ------------------------------------------------------------------
    // Main instance: boot regen, compositing, restart mid-regeneration
    // ------------------------------------------------------------------
    task automatic run_main();
        int cnt;
        step();                                          // E1: enter REGEN
        check("main_busy_e1", {15'd0, busy_m}, 16'd1);
        pix_m = C_S0;
        step();                                          // E2: stars not valid
        check("main_star_in_regen", oled_m, C_BG);
        count_busy(cnt);                                 // samples E2..E12
        check("main_busy_len", 16'(cnt), 16'd11);

        for (int i = 0; i < 9; i++) apply_vec(i);        // visible = 0

        restart_m = 1'b1;
        step();                                          // R1
        restart_m = 1'b0;
        check("restart_visible", {15'd0, vis_m}, 16'd1);
        check("restart_busy", {15'd0, busy_m}, 16'd1);
        step();                                          // R2: star0 written
        restart_m = 1'b1;
        step();                                          // R3: abort, i=0
        restart_m = 1'b0;
        check("restart2_busy", {15'd0, busy_m}, 16'd1);
        check("restart2_tick", {15'd0, tick_m}, 16'd0);
        count_busy(cnt);                                 // full NUM_STARS again
        check("restart_busy_len", 16'(cnt), 16'd12);

        for (int i = 9; i < 14; i++) apply_vec(i);       // visible = 1
    endtask

    // ------------------------------------------------------------------
    // Tick every 4 cycles; visible rises after the 3rd tick, falls after 6th
    // ------------------------------------------------------------------
    task automatic run_blink();
        for (int cyc = 1; cyc <= 36; cyc++) begin
            step();
            check($sformatf("tick_c%0d", cyc), {15'd0, tick_0},
                  ((cyc % 4) == 0) ? 16'd1 : 16'd0);
            check($sformatf("vis_c%0d", cyc), {15'd0, vis_0},
                  (cyc >= 13 && cyc <= 24) ? 16'd1 : 16'd0);
        end
    endtask

    // ------------------------------------------------------------------
    // Regen every 8 cycles, busy for 4; star field changes between regens
    // ------------------------------------------------------------------
    task automatic run_regen();
        for (int cyc = 1; cyc <= 24; cyc++) begin
            case (cyc)
                6:       pix_1 = C_S0;
                7:       pix_1 = C_R0;
                14:      pix_1 = C_S0;
                15:      pix_1 = C_R0;
                16:      pix_1 = C_R1;
                default: pix_1 = '0;
            endcase
            step();
            check($sformatf("rbusy_c%0d", cyc), {15'd0, busy_1},
                  ((cyc % 8) >= 1 && (cyc % 8) <= 4) ? 16'd1 : 16'd0);
            case (cyc)
                6:  check("regen1_star0",     oled_1, C_COL_A);
                7:  check("regen1_no_r0",     oled_1, C_BG);
                14: check("regen2_old_star0", oled_1, C_BG);
                15: check("regen2_star0",     oled_1, C_COL_A);
                16: check("regen2_star1",     oled_1, C_COL_B);
                default: ;
            endcase
        end
    endtask

    initial begin
        // visible = 0 phase
        vecs[0]  = '{C_S0,    1'b0, 1'b0, C_COL_A};
        vecs[1]  = '{C_S0B,   1'b0, 1'b0, C_COL_A};
        vecs[2]  = '{C_S1,    1'b0, 1'b0, C_COL_B};
        vecs[3]  = '{C_S1B,   1'b0, 1'b0, C_COL_B};
        vecs[4]  = '{C_S0,    1'b1, 1'b1, C_STATIC};
        vecs[5]  = '{C_S0,    1'b1, 1'b0, C_COL_A};
        vecs[6]  = '{13'd6200, 1'b0, 1'b1, C_BG};
        vecs[7]  = '{13'd6144, 1'b0, 1'b1, C_BG};
        vecs[8]  = '{13'd6143, 1'b0, 1'b1, C_STATIC};
        // visible = 1 phase
        vecs[9]  = '{C_S0,    1'b1, 1'b1, C_BLINK};
        vecs[10] = '{C_S0,    1'b0, 1'b1, C_STATIC};
        vecs[11] = '{C_S0,    1'b0, 1'b0, C_COL_A};
        vecs[12] = '{C_S1,    1'b1, 1'b0, C_BLINK};
        vecs[13] = '{13'd6200, 1'b1, 1'b0, C_BG};

        repeat (3) @(posedge clock);
        #1;
        check("rst_oled",   oled_m, C_BG);
        check("rst_visible", {15'd0, vis_m}, 16'd0);
        check("rst_busy",   {15'd0, busy_m}, 16'd0);
        check("rst_tick",   {15'd0, tick_m}, 16'd0);
        check("rst_busy_r", {15'd0, busy_1}, 16'd0);
        check("rst_tick_b", {15'd0, tick_0}, 16'd0);

        @(negedge clock);
        reset_n = 1'b1;

        fork
            run_main();
            run_blink();
            run_regen();
        join

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
